xferslice: RTL and testbench

//  Bit-stream unpacker: the transmit-side counterpart of the xferdata packer.

---
 rtl/xfer_pkg.sv | 25 ++
 rtl/xfer_mask.sv | 9 +
 rtl/xferslice.sv | 95 +++++++++
 tb/tb_xferslice.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared widths, FSM encoding and width-mask helper for the xferslice unpacker.
package xfer_pkg;
   localparam int unsigned IMSB = 31;
   localparam int unsigned OMSB = 7;
   localparam int unsigned AMSB = 5;
   localparam int unsigned IWD  = IMSB + 1;
   localparam int unsigned OWD  = OMSB + 1;
   localparam int unsigned AWD  = AMSB + 1;
   localparam int unsigned CWD  = AMSB + 2;
   localparam int unsigned BWD  = 1 << AWD;
   localparam int unsigned BWP  = BWD + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // w -> (1<<w)-1, computed one bit wider so that w==BWD yields all ones
   function automatic logic [BWD-1:0] width_mask(input logic [CWD-1:0] w);
      logic [BWD:0] one_hot;
      one_hot = BWP'(1) << w;
      return BWD'(one_hot - BWP'(1));
   endfunction
endpackage

// File: rtl/xfer_mask.sv
// Width-to-mask converter shared by the input-word and output-field paths.
module xfer_mask
   import xfer_pkg::*;
(
   input  logic [CWD-1:0] w_i,
   output logic [BWD-1:0] mask_o
);
   assign mask_o = width_mask(w_i);
endmodule

// File: rtl/xferslice.sv
// Bit-stream unpacker: wide words of variable valid width in, narrow MSB-first
// fields of variable width out, with flush producing a zero-padded final field.
module xferslice
   import xfer_pkg::*;
(
   input  logic           clk,
   input  logic           rstb,
   input  logic           iv,
   output logic           ir,
   input  logic [IWD-1:0] idat,
   input  logic [AWD-1:0] imsb,
   output logic           ov,
   input  logic           ordy,
   output logic [OWD-1:0] odat,
   input  logic [AWD-1:0] omsb,
   output logic           olast,
   input  logic           flush,
   output logic [CWD-1:0] cnt,
   output logic           empty,
   output logic           full
);
   state_e         state_q, state_d;
   logic [BWD-1:0] sbuf_q, sbuf_d;
   logic [CWD-1:0] cnt_q, cnt_d;

   logic [CWD-1:0] iw, ow, cnt_nx;
   logic [BWD-1:0] imask, omask, odat_wide;
   logic           accept, emit, residual;

   assign iw = CWD'(imsb) + CWD'(1);
   assign ow = CWD'(omsb) + CWD'(1);

   xfer_mask u_imask (.w_i(iw), .mask_o(imask));
   xfer_mask u_omask (.w_i(ow), .mask_o(omask));

   assign accept   = iv & ir;
   assign emit     = ov & ordy;
   assign residual = cnt_q < ow;
   assign cnt_nx   = cnt_q + (accept ? iw : '0) - (emit ? ow : '0);

   // State, buffer and bit count
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         sbuf_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sbuf_q  <= sbuf_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; a final residual field clears the buffer outright since cnt_nx would underflow
   always_comb begin
      state_d = state_q;
      sbuf_d  = sbuf_q;
      cnt_d   = cnt_nx;
      if (accept) sbuf_d = (sbuf_q << iw) | (BWD'(idat) & imask);
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = flush ? ST_DRAIN : ST_RUN;
         end
         ST_RUN: begin
            if (cnt_nx == '0) state_d = ST_IDLE;
            else if (flush)   state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (emit && residual) begin
               cnt_d   = '0;
               sbuf_d  = '0;
               state_d = ST_IDLE;
            end else if (cnt_nx == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshakes and field extraction; stale bits above cnt are removed by omask
   always_comb begin
      ir        = (state_q != ST_DRAIN) && (cnt_q <= CWD'(BWD - IWD));
      ov        = ((state_q == ST_RUN) && !residual) ||
                  ((state_q == ST_DRAIN) && (cnt_q != '0));
      odat_wide = residual ? ((sbuf_q << (ow - cnt_q)) & omask)
                           : ((sbuf_q >> (cnt_q - ow)) & omask);
      odat      = ov ? OWD'(odat_wide) : '0;
      olast     = ov && (state_q == ST_DRAIN) && residual;
   end

   assign cnt   = cnt_q;
   assign empty = (cnt_q == '0);
   assign full  = ~ir;
endmodule

// File: tb/tb_xferslice.sv
// Self-checking bench for xferslice: vector table, corner sequences and a random
// run against a bit-queue reference model.
module tb_xferslice;
   logic        clk = 1'b0;
   logic        rstb;
   logic        iv, ir, ov, ordy, olast, flush, empty, full;
   logic [31:0] idat;
   logic [5:0]  imsb, omsb;
   logic [7:0]  odat;
   logic [6:0]  cnt;

   int n_chk  = 0;
   int n_pass = 0;

   bit mq[$];
   bit mdrain;

   typedef struct {
      logic        iv;
      logic [31:0] idat;
      logic [5:0]  imsb;
      logic [5:0]  omsb;
      logic        ordy;
      logic        exp_ov;
      logic [7:0]  exp_odat;
      logic [6:0]  exp_cnt;
   } vec_t;
   vec_t vt[9];

   xferslice dut (
      .clk(clk), .rstb(rstb), .iv(iv), .ir(ir), .idat(idat), .imsb(imsb),
      .ov(ov), .ordy(ordy), .odat(odat), .omsb(omsb), .olast(olast),
      .flush(flush), .cnt(cnt), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int m_ow();
      return int'(omsb) + 1;
   endfunction

   function automatic bit m_ov();
      return mdrain ? (mq.size() != 0) : (mq.size() >= m_ow());
   endfunction

   function automatic bit m_ir();
      return !mdrain && (mq.size() <= 32);
   endfunction

   function automatic logic [7:0] m_odat();
      int v = 0;
      int n = mq.size();
      if (!m_ov()) return 8'h00;
      if (n >= m_ow()) begin
         for (int i = 0; i < m_ow(); i++) v = (v << 1) | int'(mq[i]);
      end else begin
         for (int i = 0; i < n; i++) v = (v << 1) | int'(mq[i]);
         v = v << (m_ow() - n);
      end
      return 8'(v);
   endfunction

   function automatic bit m_olast();
      return m_ov() && mdrain && (mq.size() < m_ow());
   endfunction

   task automatic check_model();
      chk("ov",    64'(ov),    64'(m_ov()));
      chk("ir",    64'(ir),    64'(m_ir()));
      chk("cnt",   64'(cnt),   64'(mq.size()));
      chk("odat",  64'(odat),  64'(m_odat()));
      chk("olast", 64'(olast), 64'(m_olast()));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("full",  64'(full),  64'(!m_ir()));
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] im,
                        input logic [5:0] om, input logic rd, input logic fl);
      iv = v; idat = d; imsb = im; omsb = om; ordy = rd; flush = fl;
      #1;
   endtask

   // Check outputs, clock one edge, then advance the model with the handshakes that occurred
   task automatic tick();
      bit acc, em;
      int ow;
      check_model();
      acc = iv && m_ir();
      em  = m_ov() && ordy;
      ow  = m_ow();
      @(posedge clk);
      if (em) begin
         if (mq.size() >= ow) for (int i = 0; i < ow; i++) void'(mq.pop_front());
         else mq.delete();
      end
      if (acc) for (int b = int'(imsb); b >= 0; b--) mq.push_back(idat[b]);
      if (flush && !mdrain && mq.size() != 0) mdrain = 1'b1;
      if (mdrain && mq.size() == 0) mdrain = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      drive(1'b0, 32'h0, 6'd0, 6'd7, 1'b0, 1'b0);
      @(negedge clk);
      mq.delete();
      mdrain = 1'b0;
      chk("rst_ir", 64'(ir), 64'd1);
      chk("rst_ov", 64'(ov), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_odat", 64'(odat), 64'd0);
      chk("rst_olast", 64'(olast), 64'd0);
      rstb = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      vt[0] = '{1'b1, 32'hA5C3_1E7F, 6'd31, 6'd7, 1'b1, 1'b0, 8'h00, 7'd0};
      vt[1] = '{1'b0, 32'h0,         6'd0,  6'd7, 1'b1, 1'b1, 8'hA5, 7'd32};
      vt[2] = '{1'b0, 32'h0,         6'd0,  6'd7, 1'b1, 1'b1, 8'hC3, 7'd24};
      vt[3] = '{1'b0, 32'h0,         6'd0,  6'd7, 1'b1, 1'b1, 8'h1E, 7'd16};
      vt[4] = '{1'b0, 32'h0,         6'd0,  6'd7, 1'b1, 1'b1, 8'h7F, 7'd8};
      vt[5] = '{1'b1, 32'h1D,        6'd4,  6'd3, 1'b1, 1'b0, 8'h00, 7'd0};
      vt[6] = '{1'b1, 32'h3,         6'd2,  6'd3, 1'b1, 1'b1, 8'h0E, 7'd5};
      vt[7] = '{1'b0, 32'h0,         6'd0,  6'd3, 1'b1, 1'b1, 8'h0B, 7'd4};
      vt[8] = '{1'b0, 32'h0,         6'd0,  6'd3, 1'b1, 1'b0, 8'h00, 7'd0};

      do_reset();

      for (int i = 0; i < 9; i++) begin
         drive(vt[i].iv, vt[i].idat, vt[i].imsb, vt[i].omsb, vt[i].ordy, 1'b0);
         chk($sformatf("vec%0d_ov", i),   64'(ov),   64'(vt[i].exp_ov));
         chk($sformatf("vec%0d_odat", i), 64'(odat), 64'(vt[i].exp_odat));
         chk($sformatf("vec%0d_cnt", i),  64'(cnt),  64'(vt[i].exp_cnt));
         tick();
      end

      // Backpressure: ready drops once more than BWD-IWD bits are held
      do_reset();
      drive(1'b1, 32'h0000_00F1, 6'd7, 6'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h1234_5678, 6'd31, 6'd7, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hDEAD_BEEF, 6'd31, 6'd7, 1'b0, 1'b0);
      chk("bp_cnt", 64'(cnt), 64'd40);
      chk("bp_ir", 64'(ir), 64'd0);
      chk("bp_full", 64'(full), 64'd1);
      tick();
      chk("bp_hold", 64'(cnt), 64'd40);
      for (int i = 0; i < 20 && cnt != 0; i++) begin
         drive(1'b0, 32'h0, 6'd0, 6'd7, 1'b1, 1'b0);
         tick();
      end
      chk("bp_drained", 64'(cnt), 64'd0);

      // Flush of a short residual produces a left-aligned last field
      do_reset();
      drive(1'b1, 32'h5, 6'd2, 6'd7, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 6'd0, 6'd7, 1'b1, 1'b1);
      chk("fl_pre_ov", 64'(ov), 64'd0);
      chk("fl_pre_cnt", 64'(cnt), 64'd3);
      tick();
      drive(1'b0, 32'h0, 6'd0, 6'd7, 1'b1, 1'b0);
      chk("fl_odat", 64'(odat), 64'hA0);
      chk("fl_olast", 64'(olast), 64'd1);
      chk("fl_ir", 64'(ir), 64'd0);
      tick();
      chk("fl_post_ir", 64'(ir), 64'd1);
      chk("fl_post_ov", 64'(ov), 64'd0);
      chk("fl_post_empty", 64'(empty), 64'd1);

      // Simultaneous accept and emit, then asynchronous reset mid-stream
      do_reset();
      drive(1'b1, 32'hC5, 6'd7, 6'd3, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h3A, 6'd7, 6'd3, 1'b1, 1'b0);
      chk("ae_ov", 64'(ov), 64'd1);
      chk("ae_odat", 64'(odat), 64'h0C);
      chk("ae_cnt_pre", 64'(cnt), 64'd8);
      tick();
      chk("ae_cnt_post", 64'(cnt), 64'd12);
      drive(1'b0, 32'h0, 6'd0, 6'd3, 1'b0, 1'b0);
      #1 rstb = 1'b0;
      #1;
      chk("ar_cnt", 64'(cnt), 64'd0);
      chk("ar_ov", 64'(ov), 64'd0);
      chk("ar_ir", 64'(ir), 64'd1);
      chk("ar_odat", 64'(odat), 64'd0);
      mq.delete();
      mdrain = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);

      // Randomized traffic with varying widths, backpressure and occasional flush
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 31)),
               6'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 31) == 0));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
